// File: rtl/cipher_perf_harness_if.sv
// Bus bundle between the cipher performance harness, the vector
// source, the result sink and the cipher unit under test.
//
// Ports (signals):
//   vec_*  : test vector handshake (valid/ready) and fields
//   uut_*  : drive and observe the cipher unit under test
//   res_*  : result record handshake (valid/ready) and fields
//   busy   : harness is processing a vector
// Modports:
//   master : the harness side
//   slave  : vector source / UUT / result sink side
interface cipher_perf_harness_if #(
    parameter int BLOCK_W = 64,
    parameter int KEY_W   = 80,
    parameter int ITER_W  = 16,
    parameter int CNT_W   = 32
);
    logic               vec_valid;
    logic               vec_ready;
    logic [BLOCK_W-1:0] vec_block;
    logic [KEY_W-1:0]   vec_key;
    logic [BLOCK_W-1:0] vec_expected;
    logic [1:0]         vec_mode;
    logic [ITER_W-1:0]  vec_iters;

    logic               uut_rst;
    logic               uut_ce;
    logic [BLOCK_W-1:0] uut_block_i;
    logic [KEY_W-1:0]   uut_key;
    logic               uut_encdec;
    logic [BLOCK_W-1:0] uut_block_o;
    logic               uut_end;

    logic               res_valid;
    logic               res_ready;
    logic [BLOCK_W-1:0] res_block;
    logic [CNT_W-1:0]   res_cycles;
    logic               res_pass;
    logic               res_timeout;
    logic               busy;

    modport master (
        input  vec_valid, vec_block, vec_key,
        input  vec_expected, vec_mode, vec_iters,
        output vec_ready,
        output uut_rst, uut_ce, uut_block_i,
        output uut_key, uut_encdec,
        input  uut_block_o, uut_end,
        output res_valid, res_block, res_cycles,
        output res_pass, res_timeout, busy,
        input  res_ready
    );

    modport slave (
        output vec_valid, vec_block, vec_key,
        output vec_expected, vec_mode, vec_iters,
        input  vec_ready,
        input  uut_rst, uut_ce, uut_block_i,
        input  uut_key, uut_encdec,
        output uut_block_o, uut_end,
        input  res_valid, res_block, res_cycles,
        input  res_pass, res_timeout, busy,
        output res_ready
    );
endinterface

// File: rtl/cipher_perf_harness.sv
// Block-cipher test sequencer: accepts a vector, runs the UUT for a
// number of chained passes, counts active cycles, reports a record.
//
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active-low
//   bus : cipher_perf_harness_if.master (vec_*, uut_*, res_*, busy)
module cipher_perf_harness #(
    parameter int BLOCK_W    = 64,
    parameter int KEY_W      = 80,
    parameter int ITER_W     = 16,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input logic clk,
    input logic rst,
    cipher_perf_harness_if.master bus
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int PC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        RSTU,
        RUN,
        CAPT,
        REPORT
    } state_t;

    state_t             state_q, state_d;
    logic               rt_q;
    logic               dec_q;
    logic               encdec_q;
    logic               to_q;
    logic [BLOCK_W-1:0] block_i_q;
    logic [BLOCK_W-1:0] orig_q;
    logic [BLOCK_W-1:0] exp_q;
    logic [BLOCK_W-1:0] res_block_q;
    logic [KEY_W-1:0]   key_q;
    logic [ITER_W-1:0]  iter_q;
    logic [CNT_W-1:0]   cyc_q;
    logic [PC_W-1:0]    pass_q;
    logic [RC_W-1:0]    rc_q;

    logic               rst_done;
    logic               pass_hit;
    logic               rt_turn;
    logic               last_pass;
    logic               match;

    assign rst_done  = (rc_q == RC_W'(RST_CYCLES - 1));
    // This RUN cycle is the TIMEOUT-th of the pass.
    assign pass_hit  = (pass_q == PC_W'(TIMEOUT - 1));
    // Round-trip encrypt half: decrypt half follows without
    // consuming an iteration.
    assign rt_turn   = rt_q && !encdec_q;
    assign last_pass = (iter_q == ITER_W'(1));
    assign match     = (res_block_q == (rt_q ? orig_q : exp_q));

    always_comb begin
        state_d         = state_q;
        bus.vec_ready   = 1'b0;
        bus.busy        = 1'b1;
        bus.uut_rst     = 1'b0;
        bus.uut_ce      = 1'b0;
        bus.res_valid   = 1'b0;
        bus.res_pass    = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.vec_ready = 1'b1;
                bus.busy      = 1'b0;
                bus.uut_rst   = 1'b1;
                if (bus.vec_valid) state_d = RSTU;
            end
            RSTU: begin
                bus.uut_rst = 1'b1;
                if (rst_done) state_d = RUN;
            end
            RUN: begin
                bus.uut_ce = 1'b1;
                if (bus.uut_end)   state_d = CAPT;
                else if (pass_hit) state_d = REPORT;
            end
            CAPT: begin
                if (rt_turn)        state_d = RSTU;
                else if (last_pass) state_d = REPORT;
                else                state_d = RSTU;
            end
            REPORT: begin
                bus.uut_rst   = 1'b1;
                bus.res_valid = 1'b1;
                bus.res_pass  = !to_q && match;
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rt_q        <= 1'b0;
            dec_q       <= 1'b0;
            encdec_q    <= 1'b0;
            to_q        <= 1'b0;
            block_i_q   <= '0;
            orig_q      <= '0;
            exp_q       <= '0;
            res_block_q <= '0;
            key_q       <= '0;
            iter_q      <= '0;
            cyc_q       <= '0;
            pass_q      <= '0;
            rc_q        <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= (state_q == RSTU) ? rc_q + RC_W'(1) : '0;
            unique case (state_q)
                IDLE: begin
                    if (bus.vec_valid) begin
                        block_i_q <= bus.vec_block;
                        orig_q    <= bus.vec_block;
                        exp_q     <= bus.vec_expected;
                        key_q     <= bus.vec_key;
                        rt_q      <= (bus.vec_mode == 2'b10);
                        dec_q     <= (bus.vec_mode == 2'b01);
                        encdec_q  <= (bus.vec_mode == 2'b01);
                        iter_q    <= (bus.vec_iters == '0)
                                   ? ITER_W'(1) : bus.vec_iters;
                        cyc_q     <= '0;
                        to_q      <= 1'b0;
                    end
                end
                RSTU: pass_q <= '0;
                RUN: begin
                    if (!(&cyc_q)) cyc_q <= cyc_q + CNT_W'(1);
                    pass_q <= pass_q + PC_W'(1);
                    if (!bus.uut_end && pass_hit) to_q <= 1'b1;
                end
                CAPT: begin
                    res_block_q <= bus.uut_block_o;
                    block_i_q   <= bus.uut_block_o;
                    if (rt_turn) begin
                        encdec_q <= 1'b1;
                    end else begin
                        iter_q   <= iter_q - ITER_W'(1);
                        encdec_q <= dec_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.uut_block_i = block_i_q;
    assign bus.uut_key     = key_q;
    assign bus.uut_encdec  = encdec_q;
    assign bus.res_block   = res_block_q;
    assign bus.res_cycles  = cyc_q;
    assign bus.res_timeout = to_q;

endmodule

// File: tb/tb_cipher_perf_harness.sv
// Randomised scoreboard bench for cipher_perf_harness with an
// invertible stub cipher of programmable latency.
module tb_cipher_perf_harness;

    localparam int R  = 4;
    localparam int TO = 4096;
    localparam int NEVER = 1 << 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cipher_perf_harness_if #(64, 80, 16, 32) bus ();

    cipher_perf_harness #(
        .BLOCK_W(64), .KEY_W(80), .ITER_W(16), .CNT_W(32),
        .RST_CYCLES(R), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc_now = 0;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    function automatic logic [63:0] f_enc(logic [63:0] b,
                                          logic [79:0] k);
        logic [63:0] x;
        x = b ^ k[63:0];
        return {x[56:0], x[63:57]} + k[79:16];
    endfunction

    function automatic logic [63:0] f_dec(logic [63:0] b,
                                          logic [79:0] k);
        logic [63:0] x;
        x = b - k[79:16];
        return {x[6:0], x[63:7]} ^ k[63:0];
    endfunction

    // Stub UUT: ends on its stub_len-th enabled cycle after reset.
    int stub_len = 8;
    int stub_cnt = 0;
    always @(posedge clk) begin
        if (bus.uut_rst)     stub_cnt <= 0;
        else if (bus.uut_ce) stub_cnt <= stub_cnt + 1;
    end
    assign bus.uut_end = bus.uut_ce && (stub_cnt == stub_len - 1);
    assign bus.uut_block_o = bus.uut_encdec
        ? f_dec(bus.uut_block_i, bus.uut_key)
        : f_enc(bus.uut_block_i, bus.uut_key);

    typedef struct {
        logic [63:0] blk;
        int          cyc;
        bit          pass;
        bit          to;
        int          lat;
        int          acc;
        int          stall;
    } exp_t;

    exp_t q[$];
    logic [63:0] last_blk = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic run_vec(input logic [63:0] blk,
                           input logic [79:0] key,
                           input logic [63:0] xmask,
                           input logic [1:0]  mode,
                           input int          iters,
                           input int          len,
                           input int          stall);
        int t;
        int n;
        logic [1:0]  m;
        logic [63:0] b;
        exp_t e;
        t = 0;
        while (!bus.vec_ready && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=busy want=ready");
            return;
        end
        m = (mode == 2'b11) ? 2'b00 : mode;
        n = (iters == 0) ? 1 : iters;
        b = blk;
        e.cyc = 0;
        e.lat = 0;
        e.to  = 1'b0;
        if (len > TO) begin
            e.to  = 1'b1;
            e.cyc = TO;
            e.lat = R + TO;
            e.blk = last_blk;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (m == 2'b10) begin
                    b = f_dec(f_enc(b, key), key);
                    e.cyc += 2 * len;
                    e.lat += 2 * (R + len + 1);
                end else begin
                    b = (m == 2'b01) ? f_dec(b, key) : f_enc(b, key);
                    e.cyc += len;
                    e.lat += R + len + 1;
                end
            end
            e.blk = b;
            last_blk = b;
        end
        e.pass  = !e.to && (m == 2'b10 || xmask == '0);
        e.stall = stall;
        stub_len         = len;
        bus.vec_block    = blk;
        bus.vec_key      = key;
        bus.vec_expected = b ^ xmask;
        bus.vec_mode     = mode;
        bus.vec_iters    = 16'(iters);
        bus.vec_valid    = 1'b1;
        e.acc = cyc_now + 1;
        q.push_back(e);
        @(negedge clk);
        bus.vec_valid    = 1'b0;
        bus.vec_block    = {$urandom, $urandom};
        bus.vec_expected = {$urandom, $urandom};
        bus.vec_key      = {$urandom, $urandom, $urandom};
    endtask

    task automatic chk_reset_vals();
        chk("rst_vec_ready", 64'(bus.vec_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_uut_rst", 64'(bus.uut_rst), 64'd1);
        chk("rst_uut_ce", 64'(bus.uut_ce), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_pass", 64'(bus.res_pass), 64'd0);
        chk("rst_res_timeout", 64'(bus.res_timeout), 64'd0);
        chk("rst_res_cycles", 64'(bus.res_cycles), 64'd0);
        chk("rst_res_block", bus.res_block, 64'd0);
    endtask

    // Monitor: pops and compares on each new result record, drives
    // res_ready with the requested stall, checks hold stability.
    initial begin
        exp_t e;
        bit in_rec;
        bit unstable;
        int st;
        logic [63:0] sb;
        logic [31:0] sc;
        logic sp, stt;
        in_rec = 0;
        unstable = 0;
        st = 0;
        bus.res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.res_valid) begin
                if (!in_rec) begin
                    in_rec = 1;
                    unstable = 0;
                    sb = bus.res_block;
                    sc = bus.res_cycles;
                    sp = bus.res_pass;
                    stt = bus.res_timeout;
                    st = 0;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result got=1 want=0");
                    end else begin
                        e = q.pop_front();
                        chk("res_block", bus.res_block, e.blk);
                        chk("res_cycles", 64'(bus.res_cycles),
                            64'(e.cyc));
                        chk("res_pass", 64'(bus.res_pass),
                            64'(e.pass));
                        chk("res_timeout", 64'(bus.res_timeout),
                            64'(e.to));
                        chk("latency", 64'(cyc_now - e.acc),
                            64'(e.lat));
                        st = e.stall;
                    end
                end else if (bus.res_block !== sb ||
                             bus.res_cycles !== sc ||
                             bus.res_pass !== sp ||
                             bus.res_timeout !== stt) begin
                    unstable = 1;
                end
                if (st > 0) begin
                    bus.res_ready = 1'b0;
                    st--;
                end else begin
                    bus.res_ready = 1'b1;
                end
            end else begin
                if (in_rec) begin
                    total++;
                    if (unstable) begin
                        bad++;
                        $display("FAIL hold_stable got=changed want=held");
                    end
                end
                in_rec = 0;
                bus.res_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int t;
        bus.vec_valid    = 1'b0;
        bus.vec_block    = '0;
        bus.vec_key      = '0;
        bus.vec_expected = '0;
        bus.vec_mode     = '0;
        bus.vec_iters    = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 1'b1;
        @(negedge clk);

        run_vec(64'h0, 80'h0, 64'h0, 2'b00, 1, 10, 0);
        run_vec('1, '1, 64'h0, 2'b00, 1, 7, 0);
        run_vec('1, '1, 64'h20, 2'b00, 1, 7, 1);
        run_vec(64'h5579C1387B228445, 80'h0, 64'h0, 2'b01, 1, 5, 0);
        run_vec(64'h0123456789ABCDEF, 80'h0, 64'h0, 2'b10, 1, 8, 2);
        run_vec(64'h1111, 80'h77, 64'h0, 2'b00, 3, 32, 0);
        run_vec(64'h2222, 80'h99, 64'h0, 2'b11, 0, 3, 0);
        run_vec(64'h3333, 80'h55, 64'h0, 2'b00, 1, NEVER, 10);
        run_vec(64'h4444, 80'h66, 64'h0, 2'b00, 1, TO, 0);
        run_vec(64'h5555, 80'h12, 64'h0, 2'b10, 2, 1, 0);

        // Reset in the RUN phase of pass 2 discards the vector.
        run_vec(64'h6666, 80'h34, 64'h0, 2'b00, 3, 20, 0);
        repeat (2 * R + 20 + 1 + 4) @(negedge clk);
        chk("pass2_running", 64'(bus.uut_ce), 64'd1);
        rst = 1'b0;
        #1;
        chk_reset_vals();
        void'(q.pop_back());
        last_blk = '0;
        @(negedge clk);
        chk("in_reset_no_valid", 64'(bus.res_valid), 64'd0);
        rst = 1'b1;
        run_vec(64'h7777, 80'h56, 64'h0, 2'b00, 2, 6, 0);

        for (int i = 0; i < 30; i++) begin
            run_vec({$urandom, $urandom},
                    {16'($urandom), $urandom, $urandom},
                    ($urandom_range(0, 1) == 1)
                        ? 64'h0 : (64'h1 << $urandom_range(0, 63)),
                    2'($urandom_range(0, 3)),
                    $urandom_range(0, 4),
                    $urandom_range(1, 40),
                    $urandom_range(0, 3));
        end

        t = 0;
        while (q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
